// File: rtl/tx_pkg.sv
// Shared types for the TX TLP arbitration path.
package tx_pkg;

   typedef enum logic [1:0] {
      TLP_P   = 2'd0,
      TLP_NP  = 2'd1,
      TLP_CPL = 2'd2
   } tlp_class_e;

   localparam int NUM_TLP_CLASS = 3;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   // Cyclic successor P -> NP -> CPL -> P used by the round-robin search.
   function automatic tlp_class_e next_class(input tlp_class_e c);
      case (c)
         TLP_P:   return TLP_NP;
         TLP_NP:  return TLP_CPL;
         default: return TLP_P;
      endcase
   endfunction

endpackage

// File: rtl/tx_fc_credit_gate.sv
// Per-class flow-control credit tracker: cumulative limit vs. consumed count.
module tx_fc_credit_gate
   import tx_pkg::*;
#(
   parameter int CREDIT_W     = 8,
   parameter int INIT_CREDITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                consume,
   input  logic                upd_valid,
   input  logic [CREDIT_W-1:0] upd_limit,
   output logic                avail
);

   localparam logic [CREDIT_W-1:0] HALF_RANGE = {1'b1, {(CREDIT_W-1){1'b0}}};

   logic [CREDIT_W-1:0] limit_q;
   logic [CREDIT_W-1:0] consumed_q;
   logic [CREDIT_W-1:0] diff;

   // Modulo difference; values above half range mean the limit is behind consumed.
   assign diff  = limit_q - consumed_q;
   assign avail = (diff != '0) && (diff <= HALF_RANGE);

   // Update and consume are independent, so both may land on the same edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         limit_q    <= CREDIT_W'(INIT_CREDITS);
         consumed_q <= '0;
      end else begin
         if (upd_valid) limit_q <= upd_limit;
         if (consume)   consumed_q <= consumed_q + 1'b1;
      end
   end

endmodule

// File: rtl/tx_tlp_arbiter.sv
// Round-robin, credit-gated arbiter of P/NP/CPL TLPs into a one-entry output register.
//
// state     | meaning
// ----------+-------------------------------------------------
// OUT_EMPTY | output register holds nothing, tlp_out_valid=0
// OUT_FULL  | output register holds a TLP awaiting tlp_in_ready
module tx_tlp_arbiter
   import tx_pkg::*;
#(
   parameter int DATA_W       = 1024,
   parameter int CREDIT_W     = 8,
   parameter int INIT_CREDITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DATA_W-1:0]   p_tlp_i,
   input  logic [DATA_W-1:0]   np_tlp_i,
   input  logic [DATA_W-1:0]   cpl_tlp_i,
   input  logic                p_valid_i,
   input  logic                np_valid_i,
   input  logic                cpl_valid_i,
   output logic                p_ready_o,
   output logic                np_ready_o,
   output logic                cpl_ready_o,
   input  logic                fc_upd_valid_i,
   input  logic [1:0]          fc_upd_class_i,
   input  logic [CREDIT_W-1:0] fc_upd_limit_i,
   output logic [DATA_W-1:0]   tlp_out,
   output logic                tlp_out_valid,
   input  logic                tlp_in_ready,
   output logic [1:0]          grant_class_o,
   output logic [2:0]          stall_o
);

   logic [NUM_TLP_CLASS-1:0] valid_vec;
   logic [NUM_TLP_CLASS-1:0] avail_vec;
   logic [NUM_TLP_CLASS-1:0] elig_vec;
   logic [NUM_TLP_CLASS-1:0] grant_vec;
   logic                     free;
   logic                     grant_any;
   tlp_class_e               grant_cls;
   tlp_class_e               cand;
   tlp_class_e               last_grant;
   out_state_e               state_q;
   out_state_e               state_d;
   logic [DATA_W-1:0]        tlp_mux;

   assign valid_vec = {cpl_valid_i, np_valid_i, p_valid_i};
   assign elig_vec  = valid_vec & avail_vec;
   assign free      = (state_q == OUT_EMPTY) || tlp_in_ready;

   for (genvar c = 0; c < NUM_TLP_CLASS; c++) begin : g_credit
      tx_fc_credit_gate #(
         .CREDIT_W     (CREDIT_W),
         .INIT_CREDITS (INIT_CREDITS)
      ) u_gate (
         .clk       (clk),
         .reset_n   (reset_n),
         .consume   (grant_vec[c]),
         .upd_valid (fc_upd_valid_i && (fc_upd_class_i == 2'(c))),
         .upd_limit (fc_upd_limit_i),
         .avail     (avail_vec[c])
      );
   end

   // Round-robin search starting after the last winner; no grant while in reset.
   always_comb begin
      grant_vec = '0;
      grant_cls = TLP_P;
      grant_any = 1'b0;
      cand      = next_class(last_grant);
      for (int i = 0; i < NUM_TLP_CLASS; i++) begin
         if (!grant_any && elig_vec[cand]) begin
            grant_any = 1'b1;
            grant_cls = cand;
         end
         cand = next_class(cand);
      end
      if (!(reset_n && free)) grant_any = 1'b0;
      if (grant_any) grant_vec[grant_cls] = 1'b1;
   end

   assign p_ready_o   = grant_vec[TLP_P];
   assign np_ready_o  = grant_vec[TLP_NP];
   assign cpl_ready_o = grant_vec[TLP_CPL];
   assign stall_o     = reset_n ? (valid_vec & ~avail_vec) : 3'b000;

   // Select the winning requester's data.
   always_comb begin
      tlp_mux = p_tlp_i;
      case (grant_cls)
         TLP_NP:  tlp_mux = np_tlp_i;
         TLP_CPL: tlp_mux = cpl_tlp_i;
         default: tlp_mux = p_tlp_i;
      endcase
   end

   // Output register state.
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= OUT_EMPTY;
      else          state_q <= state_d;
   end

   // A grant always fills the register; a drain without a grant empties it.
   always_comb begin
      state_d = state_q;
      if (grant_any)                                 state_d = OUT_FULL;
      else if (state_q == OUT_FULL && tlp_in_ready)  state_d = OUT_EMPTY;
   end

   assign tlp_out_valid = (state_q == OUT_FULL);

   // Load data, class and round-robin pointer on grant; clear class when drained.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tlp_out       <= '0;
         grant_class_o <= 2'd0;
         last_grant    <= TLP_CPL;
      end else if (grant_any) begin
         tlp_out       <= tlp_mux;
         grant_class_o <= grant_cls;
         last_grant    <= grant_cls;
      end else if (state_q == OUT_FULL && tlp_in_ready) begin
         grant_class_o <= 2'd0;
      end
   end

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Self-checking bench for tx_tlp_arbiter against a queue-free behavioural model.
module tb_tx_tlp_arbiter;

   localparam int DATA_W       = 1024;
   localparam int CREDIT_W     = 8;
   localparam int INIT_CREDITS = 8;
   localparam int CMOD         = 1 << CREDIT_W;
   localparam int CHALF        = 1 << (CREDIT_W - 1);

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [DATA_W-1:0]   req_data [3];
   logic                p_valid_i = 1'b0, np_valid_i = 1'b0, cpl_valid_i = 1'b0;
   logic                p_ready_o, np_ready_o, cpl_ready_o;
   logic                fc_upd_valid_i = 1'b0;
   logic [1:0]          fc_upd_class_i = 2'd0;
   logic [CREDIT_W-1:0] fc_upd_limit_i = '0;
   logic [DATA_W-1:0]   tlp_out;
   logic                tlp_out_valid;
   logic                tlp_in_ready = 1'b0;
   logic [1:0]          grant_class_o;
   logic [2:0]          stall_o;

   tx_tlp_arbiter #(
      .DATA_W(DATA_W), .CREDIT_W(CREDIT_W), .INIT_CREDITS(INIT_CREDITS)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .p_tlp_i(req_data[0]), .np_tlp_i(req_data[1]), .cpl_tlp_i(req_data[2]),
      .p_valid_i(p_valid_i), .np_valid_i(np_valid_i), .cpl_valid_i(cpl_valid_i),
      .p_ready_o(p_ready_o), .np_ready_o(np_ready_o), .cpl_ready_o(cpl_ready_o),
      .fc_upd_valid_i(fc_upd_valid_i), .fc_upd_class_i(fc_upd_class_i),
      .fc_upd_limit_i(fc_upd_limit_i),
      .tlp_out(tlp_out), .tlp_out_valid(tlp_out_valid), .tlp_in_ready(tlp_in_ready),
      .grant_class_o(grant_class_o), .stall_o(stall_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int                m_lim [3];
   int                m_con [3];
   int                m_last;
   bit                m_full;
   int                m_cls;
   logic [DATA_W-1:0] m_data;

   // per-cycle expected and observed values
   logic [2:0]        exp_ready, exp_stall, act_ready, act_stall;
   logic              act_valid;
   logic [DATA_W-1:0] act_data;
   logic [1:0]        act_cls;

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic bit has_credit(int c);
      int d;
      d = ((m_lim[c] - m_con[c]) % CMOD + CMOD) % CMOD;
      return (d >= 1) && (d <= CHALF);
   endfunction

   // One clock: predict combinational outputs, sample them, advance model on the edge,
   // then sample the registered outputs at the falling edge.
   task automatic tick();
      int g;
      int c;
      logic [2:0] vv, av;
      logic [DATA_W-1:0] g_data;
      bit rst, upd, rdy;
      int ucls, ulim;
      #1;
      vv = {cpl_valid_i, np_valid_i, p_valid_i};
      for (int k = 0; k < 3; k++) av[k] = has_credit(k);
      rst = !reset_n; upd = fc_upd_valid_i; rdy = tlp_in_ready;
      ucls = int'(fc_upd_class_i); ulim = int'(fc_upd_limit_i);
      g = -1;
      if (!rst && (!m_full || rdy)) begin
         for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (g < 0 && vv[c] && av[c]) g = c;
         end
      end
      exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_stall = rst ? 3'b000 : (vv & ~av);
      g_data    = (g >= 0) ? req_data[g] : '0;
      act_ready = {cpl_ready_o, np_ready_o, p_ready_o};
      act_stall = stall_o;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 3; k++) begin m_lim[k] = INIT_CREDITS; m_con[k] = 0; end
         m_last = 2; m_full = 0; m_cls = 0; m_data = '0;
      end else begin
         if (upd && ucls < 3) m_lim[ucls] = ulim;
         if (g >= 0) begin
            m_con[g] = (m_con[g] + 1) % CMOD;
            m_last = g; m_full = 1; m_cls = g; m_data = g_data;
         end else if (m_full && rdy) begin
            m_full = 0; m_cls = 0;
         end
      end
      @(negedge clk);
      act_valid = tlp_out_valid; act_data = tlp_out; act_cls = grant_class_o;
      if (g >= 0) req_data[g] = rand_data();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
   endtask

   task automatic set_valids(input logic [2:0] v);
      {cpl_valid_i, np_valid_i, p_valid_i} = v;
   endtask

   task automatic test_reset();
      set_valids(3'b111); tlp_in_ready = 1'b1;
      do_reset();
      n_checks++; if (act_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", act_valid); end
      n_checks++; if (act_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", act_data[63:0]); end
      n_checks++; if (act_cls !== 2'd0) begin n_fail++; $display("FAIL reset_class got %0d want 0", act_cls); end
      n_checks++; if (act_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", act_ready); end
      n_checks++; if (act_stall !== 3'b000) begin n_fail++; $display("FAIL reset_stall got %b want 000", act_stall); end
   endtask

   task automatic test_round_robin();
      logic [2:0] want;
      set_valids(3'b111); tlp_in_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         tick();
         want = 3'(1 << (i % 3));
         n_checks++; if (act_ready !== want) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", i, act_ready, want); end
         n_checks++; if (act_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", i, act_valid); end
         n_checks++; if (act_cls !== 2'(i % 3)) begin n_fail++; $display("FAIL rr_class[%0d] got %0d want %0d", i, act_cls, i % 3); end
         n_checks++; if (act_data !== m_data) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, act_data[63:0], m_data[63:0]); end
      end
   endtask

   task automatic test_credit_exhaust();
      int grants;
      set_valids(3'b001); tlp_in_ready = 1'b1;
      do_reset();
      grants = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (act_ready[0]) grants++; end
      n_checks++; if (grants !== 8) begin n_fail++; $display("FAIL exhaust_count got %0d want 8", grants); end
      n_checks++; if (act_ready !== 3'b000) begin n_fail++; $display("FAIL exhaust_ready got %b want 000", act_ready); end
      n_checks++; if (act_stall !== 3'b001) begin n_fail++; $display("FAIL exhaust_stall got %b want 001", act_stall); end
      fc_upd_valid_i = 1'b1; fc_upd_class_i = 2'd0; fc_upd_limit_i = 8'd12;
      tick();
      fc_upd_valid_i = 1'b0;
      n_checks++; if (act_ready !== 3'b000) begin n_fail++; $display("FAIL upd_cycle_ready got %b want 000", act_ready); end
      grants = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (act_ready[0]) grants++; end
      n_checks++; if (grants !== 4) begin n_fail++; $display("FAIL refill_count got %0d want 4", grants); end
      n_checks++; if (act_stall !== 3'b001) begin n_fail++; $display("FAIL refill_stall got %b want 001", act_stall); end
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] held;
      set_valids(3'b111); tlp_in_ready = 1'b0;
      do_reset();
      tick();
      n_checks++; if (act_ready !== 3'b001) begin n_fail++; $display("FAIL bp_first got %b want 001", act_ready); end
      held = m_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (act_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 000", i, act_ready); end
         n_checks++; if (act_valid !== 1'b1 || act_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, act_valid, act_data[63:0], held[63:0]); end
         n_checks++; if (act_cls !== 2'd0) begin n_fail++; $display("FAIL bp_class[%0d] got %0d want 0", i, act_cls); end
      end
      tlp_in_ready = 1'b1;
      tick();
      n_checks++; if (act_ready !== 3'b010) begin n_fail++; $display("FAIL bp_release got %b want 010", act_ready); end
      n_checks++; if (act_valid !== 1'b1 || act_cls !== 2'd1) begin n_fail++; $display("FAIL bp_reload got %b/%0d want 1/1", act_valid, act_cls); end
   endtask

   task automatic test_wrap();
      int grants, cycles;
      set_valids(3'b001);
      do_reset();
      grants = 0; cycles = 0;
      while (grants < 300 && cycles < 3000) begin
         tlp_in_ready = ($urandom_range(0, 3) != 0);
         fc_upd_valid_i = !has_credit(0);
         fc_upd_class_i = 2'd0;
         fc_upd_limit_i = CREDIT_W'((m_lim[0] + 8) % CMOD);
         tick();
         cycles++;
         if (act_ready[0]) grants++;
         n_checks++; if (act_ready !== exp_ready) begin n_fail++; $display("FAIL wrap_ready[%0d] got %b want %b", cycles, act_ready, exp_ready); end
         if (grants == 300) p_valid_i = 1'b0;
      end
      fc_upd_valid_i = 1'b0;
      n_checks++; if (grants !== 300) begin n_fail++; $display("FAIL wrap_timeout grants %0d want 300", grants); end
      n_checks++; if (m_con[0] !== 300 % CMOD) begin n_fail++; $display("FAIL wrap_consumed model %0d want %0d", m_con[0], 300 % CMOD); end
      tick(); tick();
      n_checks++; if (act_ready !== 3'b000 || act_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_extra got %b/%b want 000/0", act_ready, act_valid); end
   endtask

   task automatic test_fc_same_cycle();
      int grants;
      set_valids(3'b010); tlp_in_ready = 1'b1;
      do_reset();
      grants = 0;
      for (int i = 0; i < 7; i++) begin tick(); if (act_ready[1]) grants++; end
      n_checks++; if (grants !== 7) begin n_fail++; $display("FAIL same_pre_count got %0d want 7", grants); end
      fc_upd_valid_i = 1'b1; fc_upd_class_i = 2'd1; fc_upd_limit_i = 8'd10;
      tick();
      fc_upd_valid_i = 1'b0;
      n_checks++; if (act_ready !== 3'b010) begin n_fail++; $display("FAIL same_grant got %b want 010", act_ready); end
      tick();
      n_checks++; if (act_ready !== 3'b010) begin n_fail++; $display("FAIL same_newlimit got %b want 010", act_ready); end
      tick();
      n_checks++; if (act_ready !== 3'b010) begin n_fail++; $display("FAIL same_last got %b want 010", act_ready); end
      tick();
      n_checks++; if (act_ready !== 3'b000 || act_stall !== 3'b010) begin n_fail++; $display("FAIL same_stall got %b/%b want 000/010", act_ready, act_stall); end
   endtask

   task automatic test_reset_mid();
      set_valids(3'b111); tlp_in_ready = 1'b0;
      do_reset();
      tick(); tick();
      n_checks++; if (act_valid !== 1'b1 || act_ready !== 3'b000) begin n_fail++; $display("FAIL mid_full got %b/%b want 1/000", act_valid, act_ready); end
      set_valids(3'b110); tlp_in_ready = 1'b1;
      tick();
      n_checks++; if (act_ready !== 3'b010) begin n_fail++; $display("FAIL mid_advance got %b want 010", act_ready); end
      set_valids(3'b111); tlp_in_ready = 1'b0;
      reset_n = 1'b0;
      tick();
      n_checks++; if (act_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard got %b want 0", act_valid); end
      reset_n = 1'b1;
      tick();
      n_checks++; if (act_ready !== 3'b001) begin n_fail++; $display("FAIL mid_first_p got %b want 001", act_ready); end
   endtask

   task automatic test_random();
      logic [2:0] v;
      set_valids(3'b000);
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tlp_in_ready   = ($urandom_range(0, 9) < 7);
         fc_upd_valid_i = ($urandom_range(0, 4) == 0);
         fc_upd_class_i = 2'($urandom_range(0, 3));
         fc_upd_limit_i = CREDIT_W'((m_con[fc_upd_class_i == 2'd3 ? 0 : int'(fc_upd_class_i)] + $urandom_range(0, 6)) % CMOD);
         tick();
         n_checks++; if (act_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", i, act_ready, exp_ready); end
         n_checks++; if (act_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall[%0d] got %b want %b", i, act_stall, exp_stall); end
         n_checks++; if (act_valid !== m_full || act_cls !== 2'(m_cls)) begin n_fail++; $display("FAIL rand_out[%0d] got %b/%0d want %b/%0d", i, act_valid, act_cls, m_full, m_cls); end
         if (m_full) begin
            n_checks++; if (act_data !== m_data) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, act_data[63:0], m_data[63:0]); end
         end
         v = {cpl_valid_i, np_valid_i, p_valid_i};
         for (int c = 0; c < 3; c++)
            if (exp_ready[c] || !v[c]) v[c] = ($urandom_range(0, 1) == 1);
         set_valids(v);
      end
      fc_upd_valid_i = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) req_data[k] = rand_data();
      for (int k = 0; k < 3; k++) begin m_lim[k] = INIT_CREDITS; m_con[k] = 0; end
      m_last = 2; m_full = 0; m_cls = 0; m_data = '0;
      test_reset();
      test_round_robin();
      test_credit_exhaust();
      test_backpressure();
      test_wrap();
      test_fc_same_cycle();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
